// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one ROM read per cycle
// while buffer credit allows, and queues returning words with their PC for decode.
//   state | meaning
//   IDLE  | fetch_en low, no new reads issued
//   RUN   | fetch_en high, issue whenever credit is available
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_dout,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        pc_mem_q    [DEPTH];
  logic               pop, push, issue;
  logic [CNT_W:0]     credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_dout;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Credit counts the slot an in-flight word will need, less the one freed by a pop.
  always_comb begin
    pop         = out_valid & out_ready;
    push        = inflight_q & ~redirect_valid;
    credit_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    issue       = (state_q == RUN) & ~redirect_valid & (credit_used < (CNT_W + 1)'(DEPTH));

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (issue) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      wr_ptr_d   = rd_ptr_q;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign imem_addr = fetch_pc_q[ADDR_W+1:2];
  assign out_valid = (count_q != '0);
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign busy      = inflight_q | (count_q != '0);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios followed by random traffic, checked
// against an in-order PC-stream model with a registered ROM holding A000_0000+index.
module tb_imem_fetch_ctrl;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              fetch_en;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_dout;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              out_ready;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc;
  int          dead;
  logic        hold_valid;
  logic [31:0] hold_pc, hold_instr;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_dout(imem_dout),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    logic [ADDR_W-1:0] a;
    a = pc[ADDR_W+1:2];
    return 32'hA000_0000 + 32'(a);
  endfunction

  always @(posedge clk) imem_dout <= 32'hA000_0000 + 32'(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_pc     = RESET_PC;
    dead       = 0;
    hold_valid = 1'b0;
  endtask

  // Called at a falling edge with this cycle's inputs applied; advances one cycle.
  task automatic tick();
    if (dead > 0) begin
      chk("flush_gap_valid", {31'b0, out_valid}, 32'd0);
      dead--;
    end
    if (hold_valid) begin
      chk("hold_pc", out_pc, hold_pc);
      chk("hold_instr", out_instr, hold_instr);
    end
    chk("occupancy_le_depth", {31'b0, (int'(dut.count_q) <= DEPTH)}, 32'd1);
    hold_valid = 1'b0;
    if (redirect_valid) begin
      exp_pc = redirect_pc & ~32'h3;
      dead   = 2;
    end else if (out_valid && out_ready) begin
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_instr", out_instr, rom_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end else if (out_valid) begin
      hold_valid = 1'b1;
      hold_pc    = out_pc;
      hold_instr = out_instr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_first_valid(input string tag);
    int i;
    i = 0;
    while (!out_valid && i < 20) begin
      tick();
      i++;
    end
    chk(tag, 32'(i), 32'd3);
  endtask

  initial begin
    logic [ADDR_W-1:0] addr_snap;
    int bubbles;
    int n;

    reset_n        = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC[ADDR_W+1:2]));
    @(negedge clk);
    @(negedge clk);

    // Release and stream
    reset_n   = 1'b1;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    wait_first_valid("first_valid_cycle");
    for (int k = 0; k < 8; k++) begin
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      tick();
    end

    // Backpressure for 5 cycles
    out_ready = 1'b0;
    tick();
    tick();
    addr_snap = imem_addr;
    tick();
    tick();
    tick();
    chk("stall_imem_addr", 32'(imem_addr), 32'(addr_snap));
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();

    // Redirect to unaligned target with a pop offered in the same cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0101;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("redir_valid_t3", {31'b0, out_valid}, 32'd1);
    chk("redir_pc_t3", out_pc, 32'h0000_0100);
    chk("redir_instr_t3", out_instr, 32'hA000_0040);
    for (int k = 0; k < 4; k++) tick();

    // ROM address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0FFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr_hi", 32'(imem_addr), 32'h3FF);
    tick();
    chk("wrap_addr_lo", 32'(imem_addr), 32'h0);
    tick();
    chk("wrap_pc_ffc", out_pc, 32'h0000_0FFC);
    tick();
    chk("wrap_pc_1000", out_pc, 32'h0000_1000);
    chk("wrap_instr", out_instr, 32'hA000_0000);
    for (int k = 0; k < 3; k++) tick();

    // fetch_en low for one cycle gives exactly one bubble
    bubbles  = 0;
    fetch_en = 1'b0;
    if (!out_valid) bubbles++;
    tick();
    fetch_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (!out_valid) bubbles++;
      tick();
    end
    chk("pulse_bubbles", 32'(bubbles), 32'd1);

    // Drain with fetch held low
    fetch_en = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk("drain_busy", {31'b0, busy}, 32'd0);

    // Async reset with FIFO occupied
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_areset_valid", {31'b0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_valid", {31'b0, out_valid}, 32'd0);
    chk("areset_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    model_reset();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    wait_first_valid("restart_first_valid");
    chk("restart_pc", out_pc, RESET_PC);
    for (int k = 0; k < 4; k++) tick();

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      fetch_en       = ($urandom_range(0, 7) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom();
      tick();
    end
    redirect_valid = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("final_idle_busy", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
